rtc_seg7_clock: RTL and testbench



---
 rtl/rtc_pkg.sv | 48 ++++
 rtl/seg7_decoder.sv | 15 +
 rtl/rtc_seg7_clock.sv | 221 ++++++++++++++++++++++
 tb/tb_rtc_seg7_clock.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and helpers for the seven-segment real-time clock.
//   state_t     : time-set FSM states (alarm states exist only with RTC_ALARM_EN)
//   SEG_DIGIT   : active-low a..g patterns for BCD digits 0-9 (bit6 = a)
//   SEG_BLANK   : active-low pattern with every segment dark
//   seg_enc     : BCD + blank + polarity -> 7-bit segment vector
//   bcd59_inc   : +1 on a two-digit BCD value 00-59, 59 wraps to 00
//   hr_inc      : +1 on a binary hour 0-23, 23 wraps to 0
// Optional feature macro: RTC_ALARM_EN
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3
`ifdef RTC_ALARM_EN
    ,
    ST_SET_AL_HR  = 3'd4,
    ST_SET_AL_MIN = 3'd5
`endif
  } state_t;

  // Element 0 is the leftmost literal, so SEG_DIGIT[d] is the pattern for d.
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_enc(input logic [3:0] bcd, input logic blank,
                                         input logic act_low);
    logic [6:0] p;
    p = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd];
    return act_low ? p : ~p;
  endfunction

  // {tens, units} BCD, range 00-59.
  function automatic logic [7:0] bcd59_inc(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  function automatic logic [4:0] hr_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: one seven-segment digit.
//   i_bcd     : digit value 0-9 (10-15 render blank)
//   i_blank   : force all segments dark
//   i_act_low : 1 = lit segment drives 0
//   o_seg     : segments a..g on bits 6..0
module seg7_decoder
  import rtc_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_act_low,
  output logic [6:0] o_seg
);
  assign o_seg = seg_enc(i_bcd, i_blank, i_act_low);
endmodule

// File: rtl/rtc_seg7_clock.sv
// rtc_seg7_clock: BCD real-time clock with button time-set FSM and six
// directly driven seven-segment digits (HH:MM:SS).
//   clk, reset       : system clock (CLK_HZ) and async active-high reset
//   switch           : 1 = 12 h display, 0 = 24 h display
//   btn_mode/btn_inc : single-cycle debounced pulses (advance FSM / edit field)
//   led_a..led_f     : seconds units .. hours tens, bit6..0 = segments a..g
//   pm               : internal hour >= 12
//   set_active       : FSM is in a SET state
//   alarm_on         : (RTC_ALARM_EN only) alarm ringing
// Optional feature macro: RTC_ALARM_EN (alarm registers, two alarm-set states
// after SET_SEC, alarm_on output).
module rtc_seg7_clock
  import rtc_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int RESET_HOUR     = 0,
  parameter int RESET_MIN      = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] led_a,
  output logic [6:0] led_b,
  output logic [6:0] led_c,
  output logic [6:0] led_d,
  output logic [6:0] led_e,
  output logic [6:0] led_f,
  output logic       pm,
  output logic       set_active
`ifdef RTC_ALARM_EN
  ,
  output logic       alarm_on
`endif
);
  localparam int            PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0] P_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF  = PW'(CLK_HZ / 2);
  localparam logic          ACT_LOW = (SEG_ACTIVE_LOW != 0);

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [7:0]      r_sec, r_min;   // BCD {tens, units}
  logic [4:0]      r_hour;         // binary 0-23
  logic [5:0][6:0] r_seg;          // [0] = led_a .. [5] = led_f
  logic            r_pm, r_set;
  logic            w_tick;

  assign w_tick = (r_presc == P_MAX);

  // ---------------- time-set FSM and time-of-day cascade ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_presc <= '0;
      r_sec   <= 8'h00;
      r_min   <= {4'(RESET_MIN / 10), 4'(RESET_MIN % 10)};
      r_hour  <= 5'(RESET_HOUR);
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (btn_mode) begin
        // mode wins: any inc or tick on this cycle is dropped
        case (r_state)
          ST_RUN:     r_state <= ST_SET_HR;
          ST_SET_HR:  r_state <= ST_SET_MIN;
          ST_SET_MIN: r_state <= ST_SET_SEC;
`ifdef RTC_ALARM_EN
          ST_SET_SEC:    r_state <= ST_SET_AL_HR;
          ST_SET_AL_HR:  r_state <= ST_SET_AL_MIN;
          ST_SET_AL_MIN: begin r_state <= ST_RUN; r_presc <= '0; end
`else
          ST_SET_SEC: begin r_state <= ST_RUN; r_presc <= '0; end
`endif
          default:    r_state <= ST_RUN;
        endcase
      end else begin
        case (r_state)
          ST_RUN: if (w_tick) begin
            r_sec <= bcd59_inc(r_sec);
            if (r_sec == 8'h59) begin
              r_min <= bcd59_inc(r_min);
              if (r_min == 8'h59) r_hour <= hr_inc(r_hour);
            end
          end
          ST_SET_HR:  if (btn_inc) r_hour <= hr_inc(r_hour);
          ST_SET_MIN: if (btn_inc) r_min <= bcd59_inc(r_min);  // no carry into hour
          ST_SET_SEC: if (btn_inc) r_sec <= 8'h00;
          default: ;
        endcase
      end
    end
  end

`ifdef RTC_ALARM_EN
  // ---------------- alarm ----------------
  logic [4:0] r_al_hour;
  logic [7:0] r_al_min;
  logic       r_al_en, r_alarm_on;
  logic [5:0] r_al_cnt;
  logic       w_al_hit;

  // this tick lands on hh:mm:00 equal to the alarm time
  assign w_al_hit = (r_sec == 8'h59) && (bcd59_inc(r_min) == r_al_min) &&
                    (((r_min == 8'h59) ? hr_inc(r_hour) : r_hour) == r_al_hour);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_al_hour  <= 5'd0;
      r_al_min   <= 8'h00;
      r_al_en    <= 1'b0;
      r_alarm_on <= 1'b0;
      r_al_cnt   <= 6'd0;
    end else begin
      if (!btn_mode && btn_inc && r_state == ST_SET_AL_HR)  r_al_hour <= hr_inc(r_al_hour);
      if (!btn_mode && btn_inc && r_state == ST_SET_AL_MIN) r_al_min  <= bcd59_inc(r_al_min);
      if (btn_mode && r_state == ST_SET_AL_HR) r_al_en <= 1'b1;
      if (r_state == ST_RUN && !btn_mode) begin
        if (w_tick && r_al_en && w_al_hit) begin
          r_alarm_on <= 1'b1;
          r_al_cnt   <= 6'd0;
        end else if (r_alarm_on) begin
          if (btn_inc) r_alarm_on <= 1'b0;
          else if (w_tick) begin
            if (r_al_cnt == 6'd59) r_alarm_on <= 1'b0;
            else                   r_al_cnt   <= r_al_cnt + 6'd1;
          end
        end
      end
    end
  end

  assign alarm_on = r_alarm_on;
`endif

  // ---------------- display path ----------------
  logic [4:0]      w_dsp_hour, w_dh;
  logic [7:0]      w_dsp_min, w_dsp_sec;
  logic [3:0]      w_h_hi, w_h_lo;
  logic            w_edit_h, w_edit_m, w_edit_s, w_blink;
  logic [5:0][3:0] w_bcd;
  logic [5:0]      w_blank;
  logic [5:0][6:0] w_seg;

  always_comb begin
    w_dsp_hour = r_hour;
    w_dsp_min  = r_min;
    w_dsp_sec  = r_sec;
    w_edit_h   = (r_state == ST_SET_HR);
    w_edit_m   = (r_state == ST_SET_MIN);
    w_edit_s   = (r_state == ST_SET_SEC);
`ifdef RTC_ALARM_EN
    // while editing the alarm, show the alarm time with seconds 00
    if (r_state == ST_SET_AL_HR || r_state == ST_SET_AL_MIN) begin
      w_dsp_hour = r_al_hour;
      w_dsp_min  = r_al_min;
      w_dsp_sec  = 8'h00;
    end
    w_edit_h = w_edit_h || (r_state == ST_SET_AL_HR);
    w_edit_m = w_edit_m || (r_state == ST_SET_AL_MIN);
`endif
  end

  // 12 h mapping: 0 -> 12, 13..23 -> 1..11
  always_comb begin
    w_dh = w_dsp_hour;
    if (switch) begin
      if (w_dsp_hour == 5'd0)       w_dh = 5'd12;
      else if (w_dsp_hour > 5'd12)  w_dh = w_dsp_hour - 5'd12;
    end
    if (w_dh >= 5'd20)      begin w_h_hi = 4'd2; w_h_lo = 4'(w_dh - 5'd20); end
    else if (w_dh >= 5'd10) begin w_h_hi = 4'd1; w_h_lo = 4'(w_dh - 5'd10); end
    else                    begin w_h_hi = 4'd0; w_h_lo = 4'(w_dh);         end
  end

  // edited field is dark during the second half of each second
  assign w_blink = (r_presc >= P_HALF);
  assign w_bcd   = {w_h_hi, w_h_lo, w_dsp_min[7:4], w_dsp_min[3:0],
                    w_dsp_sec[7:4], w_dsp_sec[3:0]};
  assign w_blank = {(w_blink && w_edit_h) || (switch && w_h_hi == 4'd0),
                    w_blink && w_edit_h,
                    w_blink && w_edit_m, w_blink && w_edit_m,
                    w_blink && w_edit_s, w_blink && w_edit_s};

  for (genvar g = 0; g < 6; g++) begin : g_dig
    seg7_decoder u_dec (
      .i_bcd    (w_bcd[g]),
      .i_blank  (w_blank[g]),
      .i_act_low(ACT_LOW),
      .o_seg    (w_seg[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= {seg_enc(4'(RESET_HOUR / 10), 1'b0, ACT_LOW),
                seg_enc(4'(RESET_HOUR % 10), 1'b0, ACT_LOW),
                seg_enc(4'(RESET_MIN / 10),  1'b0, ACT_LOW),
                seg_enc(4'(RESET_MIN % 10),  1'b0, ACT_LOW),
                seg_enc(4'd0, 1'b0, ACT_LOW),
                seg_enc(4'd0, 1'b0, ACT_LOW)};
      r_pm  <= (RESET_HOUR >= 12);
      r_set <= 1'b0;
    end else begin
      r_seg <= w_seg;
      r_pm  <= (r_hour >= 5'd12);
      r_set <= (r_state != ST_RUN);
    end
  end

  assign led_a      = r_seg[0];
  assign led_b      = r_seg[1];
  assign led_c      = r_seg[2];
  assign led_d      = r_seg[3];
  assign led_e      = r_seg[4];
  assign led_f      = r_seg[5];
  assign pm         = r_pm;
  assign set_active = r_set;

endmodule

// File: tb/tb_rtc_seg7_clock.sv
// tb_rtc_seg7_clock: directed bench for rtc_seg7_clock with CLK_HZ=4,
// reset time 23:59, active-low segments. Alarm checks compile only with
// RTC_ALARM_EN.
module tb_rtc_seg7_clock;
  localparam int B = 15;  // blank digit marker for disp()

  logic clk = 1'b0, reset = 1'b1, switch = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [6:0] led_a, led_b, led_c, led_d, led_e, led_f;
  logic pm, set_active;
`ifdef RTC_ALARM_EN
  logic alarm_on;
`endif
  logic [41:0] leds;
  int n_tot = 0, n_bad = 0;

  rtc_seg7_clock #(.CLK_HZ(4), .RESET_HOUR(23), .RESET_MIN(59), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .switch(switch), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .led_a(led_a), .led_b(led_b), .led_c(led_c), .led_d(led_d), .led_e(led_e), .led_f(led_f),
    .pm(pm), .set_active(set_active)
`ifdef RTC_ALARM_EN
    , .alarm_on(alarm_on)
`endif
  );

  always #5 clk = ~clk;
  assign leds = {led_f, led_e, led_d, led_c, led_b, led_a};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] disp(input int ht, hu, mt, mu, st, su);
    return {seg(ht), seg(hu), seg(mt), seg(mu), seg(st), seg(su)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive buttons for n consecutive edges
  task automatic press(input logic m, input logic i, input int n = 1);
    btn_mode = m;
    btn_inc  = i;
    step(n);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
    $fatal(1);
  end

  initial begin
    // reset state
    step(3);
    chk("rst_disp", leds, disp(2, 3, 5, 9, 0, 0));
    chk("rst_pm", pm, 1);
    chk("rst_set", set_active, 0);
`ifdef RTC_ALARM_EN
    chk("rst_alarm", alarm_on, 0);
`endif
    // first tick exactly 4 cycles after release, shown one cycle later
    reset = 1'b0;
    step(4); chk("tick_early", leds, disp(2, 3, 5, 9, 0, 0));
    step(1); chk("tick_first", leds, disp(2, 3, 5, 9, 0, 1));
    // run to 23:59:59 then day wrap
    step(232); chk("pre_wrap", leds, disp(2, 3, 5, 9, 5, 9));
    chk("pre_wrap_pm", pm, 1);
    step(4); chk("wrap", leds, disp(0, 0, 0, 0, 0, 0));
    chk("wrap_pm", pm, 0);
    // 12 h: hour 0 shows 12
    switch = 1'b1;
    step(1); chk("h12_midnight", leds, disp(1, 2, 0, 0, 0, 0));
    // mode+inc together, on the same edge as a tick
    step(1); press(1'b1, 1'b1);
    step(1); chk("mode_beats_inc", set_active, 1);
    chk("tick_dropped", leds, disp(1, 2, 0, 0, 0, 0));
    step(2); chk("blink_hr", leds, disp(B, B, 0, 0, 0, 0));
    // hour 13 in 12 h, then back to RUN with cleared prescaler
    press(1'b0, 1'b1, 13);
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
    step(1); chk("h12_13", leds, disp(B, 1, 0, 0, 0, 0));
    chk("h12_13_pm", pm, 1);
    chk("run_set", set_active, 0);
    step(3); chk("presc_clr_early", leds, disp(B, 1, 0, 0, 0, 0));
    step(1); chk("presc_clr_tick", leds, disp(B, 1, 0, 0, 0, 1));
    // 24 h: 13 + 21 wraps to 10, + 25 -> 11
    switch = 1'b0;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1, 21);
    press(1'b0, 1'b1, 25);
    press(1'b1, 1'b0);
    step(1); chk("set_hr_11", {led_f, led_e}, {seg(1), seg(1)});
    chk("set_min_active", set_active, 1);
    // minute 00 -> 59, seconds cleared in SET_SEC
    press(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    step(1); chk("set_min_59", {led_f, led_e, led_d, led_c}, {seg(1), seg(1), seg(5), seg(9)});
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    step(1); chk("set_done", leds, disp(1, 1, 5, 9, 0, 0));
    // minute 59 -> 00 without hour carry
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    step(1); chk("min_wrap", leds, disp(1, 1, 0, 0, 0, 0));
    // reset in SET_MIN acts immediately
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_async_set", set_active, 0);
    chk("rst_async_disp", leds, disp(2, 3, 5, 9, 0, 0));
    chk("rst_async_pm", pm, 1);
    step(2);
`ifdef RTC_ALARM_EN
    // time 00:00:00, alarm 00:01 armed
    reset = 1'b0;
    press(1'b1, 1'b0); press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    step(239); chk("al_early", alarm_on, 0);
    step(1);   chk("al_on", alarm_on, 1);
    press(1'b0, 1'b1); chk("al_clear", alarm_on, 0);
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
